// File: rtl/maze_pkg.sv
// Shared maze geometry and cell-indexing conventions for the pellet map,
// the pellet renderer and the position-to-cell logic.
package maze_pkg;

    localparam int unsigned MAZE_ROWS  = 8;
    localparam int unsigned MAZE_COLS  = 8;
    localparam int unsigned MAZE_CELLS = MAZE_ROWS * MAZE_COLS;

    // Default geometry: 32x32 pixel cells, maze origin at (64,112)
    localparam int unsigned DEF_CELL_SHIFT  = 5;
    localparam int unsigned DEF_MAZE_X0     = 64;
    localparam int unsigned DEF_MAZE_Y0     = 112;
    localparam int unsigned DEF_PELLET_HALF = 3;

    localparam int unsigned CELL_IDX_W = 6;
    localparam int unsigned COUNT_W    = 7;

    typedef enum logic {
        CNT_IDLE,
        CNT_COUNT
    } count_state_e;

    // Cell index convention: idx = row*8 + col
    function automatic logic [CELL_IDX_W-1:0] cell_index(input logic [2:0] row,
                                                         input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/pellet_counter.sv
// Serial per-frame pellet counter: walks the snapshot one cell per cycle,
// publishes the total and flags a cleared level.
module pellet_counter
    import maze_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic [0:MAZE_CELLS-1]   snap,
    output logic [COUNT_W-1:0]      pellets_left,
    output logic                    count_done,
    output logic                    level_clear
);

    count_state_e state_q, state_d;

    logic [COUNT_W-1:0]    acc_q, acc_d;
    logic [CELL_IDX_W-1:0] ptr_q, ptr_d;
    logic [COUNT_W-1:0]    pellets_left_q, pellets_left_d;
    logic                  count_done_q, count_done_d;
    logic                  level_clear_q, level_clear_d;
    logic [COUNT_W-1:0]    acc_sum;
    logic                  last_cell;

    assign acc_sum   = acc_q + {{(COUNT_W-1){1'b0}}, snap[ptr_q]};
    assign last_cell = (ptr_q == '1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CNT_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: frame_start always (re)starts a scan
    always_comb begin
        state_d = state_q;
        case (state_q)
            CNT_IDLE:  if (frame_start) state_d = CNT_COUNT;
            CNT_COUNT: begin
                if (frame_start)    state_d = CNT_COUNT;
                else if (last_cell) state_d = CNT_IDLE;
            end
            default:   state_d = CNT_IDLE;
        endcase
    end

    // Datapath/outputs: a restart takes priority over the final add, so an
    // aborted scan never publishes a count
    always_comb begin
        acc_d          = acc_q;
        ptr_d          = ptr_q;
        pellets_left_d = pellets_left_q;
        count_done_d   = 1'b0;
        level_clear_d  = level_clear_q;
        if (frame_start) begin
            acc_d = '0;
            ptr_d = '0;
        end else if (state_q == CNT_COUNT) begin
            acc_d = acc_sum;
            ptr_d = ptr_q + 1'b1;
            if (last_cell) begin
                pellets_left_d = acc_sum;
                count_done_d   = 1'b1;
                if (acc_sum == '0) level_clear_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q          <= '0;
            ptr_q          <= '0;
            pellets_left_q <= '0;
            count_done_q   <= 1'b0;
            level_clear_q  <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            ptr_q          <= ptr_d;
            pellets_left_q <= pellets_left_d;
            count_done_q   <= count_done_d;
            level_clear_q  <= level_clear_d;
        end
    end

    assign pellets_left = pellets_left_q;
    assign count_done   = count_done_q;
    assign level_clear  = level_clear_q;

endmodule

// File: rtl/pellet_renderer.sv
// Pellet reader: per-frame snapshot of the pellet map, 2-stage pixel
// pipeline producing the pellet draw flag, and the serial pellet counter.
module pellet_renderer
    import maze_pkg::*;
#(
    parameter int unsigned CELL_SHIFT  = DEF_CELL_SHIFT,
    parameter int unsigned MAZE_X0     = DEF_MAZE_X0,
    parameter int unsigned MAZE_Y0     = DEF_MAZE_Y0,
    parameter int unsigned PELLET_HALF = DEF_PELLET_HALF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pixel_valid,
    input  logic [9:0]             hpos,
    input  logic [9:0]             vpos,
    input  logic [0:MAZE_CELLS-1]  pellet_arr,
    output logic                   pellet_px,
    output logic                   px_valid,
    output logic [COUNT_W-1:0]     pellets_left,
    output logic                   count_done,
    output logic                   level_clear
);

    localparam int unsigned CELL_PX   = 1 << CELL_SHIFT;
    localparam int unsigned MAZE_SPAN = MAZE_COLS << CELL_SHIFT;
    localparam logic [CELL_SHIFT-1:0] PEL_LO = CELL_SHIFT'(CELL_PX / 2 - PELLET_HALF);
    localparam logic [CELL_SHIFT-1:0] PEL_HI = CELL_SHIFT'(CELL_PX / 2 + PELLET_HALF - 1);

    logic [0:MAZE_CELLS-1]  snap_q, snap_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_in_maze_q, s1_in_maze_d;
    logic [CELL_IDX_W-1:0]  s1_idx_q, s1_idx_d;
    logic [CELL_SHIFT-1:0]  s1_ox_q, s1_ox_d, s1_oy_q, s1_oy_d;
    logic                   pellet_px_q, pellet_px_d;
    logic                   px_valid_q, px_valid_d;
    logic signed [10:0]     dx, dy;

    // Snapshot and stage 1: scan position to maze cell and in-cell offset
    always_comb begin
        snap_d       = frame_start ? pellet_arr : snap_q;
        dx           = $signed({1'b0, hpos}) - $signed(11'(MAZE_X0));
        dy           = $signed({1'b0, vpos}) - $signed(11'(MAZE_Y0));
        s1_valid_d   = pixel_valid;
        s1_in_maze_d = !dx[10] && !dy[10] &&
                       (dx < $signed(11'(MAZE_SPAN))) && (dy < $signed(11'(MAZE_SPAN)));
        s1_idx_d     = cell_index(dy[CELL_SHIFT+2:CELL_SHIFT], dx[CELL_SHIFT+2:CELL_SHIFT]);
        s1_ox_d      = dx[CELL_SHIFT-1:0];
        s1_oy_d      = dy[CELL_SHIFT-1:0];
    end

    // Stage 2: live pellet lookup and centred sprite window test
    always_comb begin
        px_valid_d  = s1_valid_q;
        pellet_px_d = s1_valid_q && s1_in_maze_q && snap_q[s1_idx_q] &&
                      (s1_ox_q >= PEL_LO) && (s1_ox_q <= PEL_HI) &&
                      (s1_oy_q >= PEL_LO) && (s1_oy_q <= PEL_HI);
    end

    // Snapshot and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_in_maze_q <= 1'b0;
            s1_idx_q     <= '0;
            s1_ox_q      <= '0;
            s1_oy_q      <= '0;
            pellet_px_q  <= 1'b0;
            px_valid_q   <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            s1_valid_q   <= s1_valid_d;
            s1_in_maze_q <= s1_in_maze_d;
            s1_idx_q     <= s1_idx_d;
            s1_ox_q      <= s1_ox_d;
            s1_oy_q      <= s1_oy_d;
            pellet_px_q  <= pellet_px_d;
            px_valid_q   <= px_valid_d;
        end
    end

    assign pellet_px = pellet_px_q;
    assign px_valid  = px_valid_q;

    pellet_counter u_counter (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .snap         (snap_q),
        .pellets_left (pellets_left),
        .count_done   (count_done),
        .level_clear  (level_clear)
    );

endmodule
